// File: rtl/pcie_slv_mailbox.sv
// pcie_slv_mailbox
//   BAR0 slave-bus target with a small register file and two mailboxes.
//   H2L carries host writes to local logic, and L2H carries local writes back to the host.
//
// Ports
//   pcie_clk, sys_rst_n      : clock and asynchronous active-low reset
//   slv_bar_i/ce/we/adr/dat/sel : slave bus request; only BAR0 hits are served
//   slv_dat_o                : registered read data, valid the cycle after the strobe
//   h2l_rd_en/h2l_dat/h2l_empty : local show-ahead pop side of the H2L mailbox
//   l2h_wr_en/l2h_dat/l2h_full  : local push side of the L2H mailbox
//   led                      : CTRL[7:0] inverted for active-low board LEDs
//
// Register map (halfword offset slv_adr_i[3:1])
//   0 ID  1 CTRL  2 SCRATCH  3 STATUS  4 H2L_DATA(WO)  5 L2H_DATA(RO, pop)
//   6 ERR(W1C)  7 reserved
module pcie_slv_mailbox #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [15:0] ID_VALUE   = 16'h1A2B
) (
  input  logic        pcie_clk,
  input  logic        sys_rst_n,
  input  logic [6:0]  slv_bar_i,
  input  logic        slv_ce_i,
  input  logic        slv_we_i,
  input  logic [19:1] slv_adr_i,
  input  logic [15:0] slv_dat_i,
  input  logic [1:0]  slv_sel_i,
  output logic [15:0] slv_dat_o,
  input  logic        h2l_rd_en,
  output logic [15:0] h2l_dat,
  output logic        h2l_empty,
  input  logic        l2h_wr_en,
  input  logic [15:0] l2h_dat,
  output logic        l2h_full,
  output logic [7:0]  led
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]         FULL_COUNT = CW'(DEPTH);
  localparam logic [CW-1:0]         CNT_ONE    = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic        acc;
  logic        host_wr;
  logic        host_rd;
  logic        sel_any;
  logic [2:0]  offset;
  logic [15:0] lane_mask;

  assign acc     = slv_ce_i & slv_bar_i[0];
  assign host_wr = acc & slv_we_i;
  assign host_rd = acc & ~slv_we_i;
  assign sel_any = |slv_sel_i;
  assign offset  = slv_adr_i[3:1];

  // Expand each byte enable across its lane.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      assign lane_mask[gi*8 +: 8] = {8{slv_sel_i[gi]}};
    end
  endgenerate

  // Address bits above [3:1] and the other BAR hits play no part in decode.
  logic unused_bits;
  assign unused_bits = ^{slv_bar_i[6:1], slv_adr_i[19:4]};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [14:0] ctrl_reg;
  logic [15:0] scratch_reg;
  logic [2:0]  err_reg;

  logic [15:0]           h2l_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] h2l_wr_ptr_reg, h2l_rd_ptr_reg;
  logic [CW-1:0]         h2l_count_reg;

  logic [15:0]           l2h_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] l2h_wr_ptr_reg, l2h_rd_ptr_reg;
  logic [CW-1:0]         l2h_count_reg;

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic h2l_is_full, h2l_is_empty, l2h_is_full, l2h_is_empty;
  logic flush;
  logic h2l_push_req, h2l_push_ok, h2l_pop_ok;
  logic l2h_pop_req, l2h_push_ok, l2h_pop_ok;

  assign h2l_is_full  = (h2l_count_reg == FULL_COUNT);
  assign h2l_is_empty = (h2l_count_reg == '0);
  assign l2h_is_full  = (l2h_count_reg == FULL_COUNT);
  assign l2h_is_empty = (l2h_count_reg == '0);

  // FLUSH is only meaningful when the upper lane is actually written.
  assign flush = host_wr & (offset == 3'd1) & slv_sel_i[1] & slv_dat_i[15];

  // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
  assign h2l_push_req = host_wr & (offset == 3'd4) & sel_any;
  assign h2l_pop_ok   = h2l_rd_en & ~h2l_is_empty;
  assign h2l_push_ok  = h2l_push_req & (~h2l_is_full | h2l_pop_ok);

  assign l2h_pop_req  = host_rd & (offset == 3'd5);
  assign l2h_pop_ok   = l2h_pop_req & ~l2h_is_empty;
  assign l2h_push_ok  = l2h_wr_en & (~l2h_is_full | l2h_pop_ok);

  // ---------------------------------------------------------------------------
  // Register next values
  // ---------------------------------------------------------------------------
  logic [14:0] ctrl_next;
  logic [15:0] scratch_next;
  logic [2:0]  err_set, err_clr, err_next;

  assign ctrl_next    = (ctrl_reg & ~lane_mask[14:0]) | (slv_dat_i[14:0] & lane_mask[14:0]);
  assign scratch_next = (scratch_reg & ~lane_mask) | (slv_dat_i & lane_mask);

  assign err_set = {l2h_wr_en & l2h_is_full & ~l2h_pop_ok,
                    l2h_pop_req & l2h_is_empty,
                    h2l_push_req & h2l_is_full & ~h2l_pop_ok};
  assign err_clr = (host_wr && offset == 3'd6) ? (slv_dat_i[2:0] & lane_mask[2:0]) : 3'b000;
  // A set in the same cycle as its clear wins.
  assign err_next = (err_reg & ~err_clr) | err_set;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [15:0] status_word;
  logic [15:0] rd_data;

  always_comb begin
    status_word           = '0;
    status_word[8 +: CW]  = h2l_count_reg;
    status_word[0 +: CW]  = l2h_count_reg;
  end

  always_comb begin
    rd_data = '0;
    case (offset)
      3'd0:    rd_data = ID_VALUE;
      3'd1:    rd_data = {1'b0, ctrl_reg};
      3'd2:    rd_data = scratch_reg;
      3'd3:    rd_data = status_word;
      3'd5:    rd_data = l2h_is_empty ? 16'h0000 : l2h_mem[l2h_rd_ptr_reg];
      3'd6:    rd_data = {13'b0, err_reg};
      default: rd_data = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      slv_dat_o   <= '0;
      ctrl_reg    <= '0;
      scratch_reg <= '0;
      err_reg     <= '0;
    end else begin
      if (host_rd) begin
        slv_dat_o <= rd_data;
      end
      if (host_wr && offset == 3'd1) begin
        ctrl_reg <= ctrl_next;
      end
      if (host_wr && offset == 3'd2) begin
        scratch_reg <= scratch_next;
      end
      err_reg <= err_next;
    end
  end

  // H2L pointers and count; flush overrides any coincident push or pop.
  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h2l_wr_ptr_reg <= '0;
      h2l_rd_ptr_reg <= '0;
      h2l_count_reg  <= '0;
    end else if (flush) begin
      h2l_wr_ptr_reg <= '0;
      h2l_rd_ptr_reg <= '0;
      h2l_count_reg  <= '0;
    end else begin
      if (h2l_push_ok) h2l_wr_ptr_reg <= h2l_wr_ptr_reg + PTR_ONE;
      if (h2l_pop_ok)  h2l_rd_ptr_reg <= h2l_rd_ptr_reg + PTR_ONE;
      case ({h2l_push_ok, h2l_pop_ok})
        2'b10:   h2l_count_reg <= h2l_count_reg + CNT_ONE;
        2'b01:   h2l_count_reg <= h2l_count_reg - CNT_ONE;
        default: h2l_count_reg <= h2l_count_reg;
      endcase
    end
  end

  // L2H pointers and count.
  always_ff @(posedge pcie_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      l2h_wr_ptr_reg <= '0;
      l2h_rd_ptr_reg <= '0;
      l2h_count_reg  <= '0;
    end else if (flush) begin
      l2h_wr_ptr_reg <= '0;
      l2h_rd_ptr_reg <= '0;
      l2h_count_reg  <= '0;
    end else begin
      if (l2h_push_ok) l2h_wr_ptr_reg <= l2h_wr_ptr_reg + PTR_ONE;
      if (l2h_pop_ok)  l2h_rd_ptr_reg <= l2h_rd_ptr_reg + PTR_ONE;
      case ({l2h_push_ok, l2h_pop_ok})
        2'b10:   l2h_count_reg <= l2h_count_reg + CNT_ONE;
        2'b01:   l2h_count_reg <= l2h_count_reg - CNT_ONE;
        default: l2h_count_reg <= l2h_count_reg;
      endcase
    end
  end

  // Storage arrays carry no reset; the counts alone define valid contents.
  always_ff @(posedge pcie_clk) begin
    if (h2l_push_ok && !flush) begin
      h2l_mem[h2l_wr_ptr_reg] <= slv_dat_i & lane_mask;
    end
    if (l2h_push_ok && !flush) begin
      l2h_mem[l2h_wr_ptr_reg] <= l2h_dat;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign h2l_empty = h2l_is_empty;
  assign h2l_dat   = h2l_is_empty ? 16'h0000 : h2l_mem[h2l_rd_ptr_reg];
  assign l2h_full  = l2h_is_full;
  assign led       = ~ctrl_reg[7:0];

endmodule
